// File: rtl/if_fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package if_fetch_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'hBFC0_0000;
    localparam logic [31:0] ZERO_WORD        = 32'h0000_0000;
    localparam logic [31:0] PC_STEP          = 32'd4;

    // S_FETCH: request out; S_HOLD: word buffered until IF/ID accepts;
    // S_DROP: stale request still out, result discarded; S_ERR: misaligned PC parked.
    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_HOLD  = 2'd1,
        S_DROP  = 2'd2,
        S_ERR   = 2'd3
    } if_state_e;

    function automatic logic pc_misaligned(input logic [31:0] pc);
        return pc[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/if_fetch.sv
// Instruction fetch: owns the PC, fetches words over inst_req/inst_ack, presents {pc,inst,valid} to IF/ID.
// Latency: combinational from inst_ack to if_valid/if_inst; PC advances on the clock after acceptance.
// Backpressure: stall holds the presented word (buffered if it arrived under stall); stallreq while a fetch waits.
//
// Ports:
//   clk, rst (sync, active-high)
//   stall            IF/ID not accepting this cycle
//   flush, new_pc    exception restart; discards any in-flight fetch
//   branch_flag, branch_target   redirect applied after the current (delay-slot) fetch
//   inst_req, inst_addr, inst_ack, inst_rdata   instruction memory handshake
//   if_pc, if_inst, if_valid, if_adel           presented slot
//   stallreq         fetch outstanding with no ack this cycle
module if_fetch
    import if_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        flush,
    input  logic [31:0] new_pc,
    input  logic        branch_flag,
    input  logic [31:0] branch_target,
    output logic        inst_req,
    output logic [31:0] inst_addr,
    input  logic        inst_ack,
    input  logic [31:0] inst_rdata,
    output logic [31:0] if_pc,
    output logic [31:0] if_inst,
    output logic        if_valid,
    output logic        if_adel,
    output logic        stallreq
);

    if_state_e   state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] pend_target_q, pend_target_d;
    logic        pend_valid_q, pend_valid_d;
    logic [31:0] hold_inst_q, hold_inst_d;
    logic [31:0] drop_addr_q, drop_addr_d;
    logic        err_acc_q, err_acc_d;
    logic        pc_adv;

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        pend_target_d = pend_target_q;
        pend_valid_d  = pend_valid_q;
        hold_inst_d   = hold_inst_q;
        drop_addr_d   = drop_addr_q;
        err_acc_d     = err_acc_q;
        pc_adv        = 1'b0;

        inst_req  = 1'b0;
        inst_addr = pc_q;
        if_pc     = pc_q;
        if_inst   = ZERO_WORD;
        if_valid  = 1'b0;
        if_adel   = 1'b0;
        stallreq  = 1'b0;

        case (state_q)
            S_FETCH: begin
                inst_req = 1'b1;
                stallreq = !inst_ack;
                if (inst_ack) begin
                    if_valid = 1'b1;
                    if_inst  = inst_rdata;
                    if (stall) begin
                        hold_inst_d = inst_rdata;
                        state_d     = S_HOLD;
                    end else begin
                        pc_adv = 1'b1;
                    end
                end
            end
            S_HOLD: begin
                if_valid = 1'b1;
                if_inst  = hold_inst_q;
                if (!stall) begin
                    pc_adv  = 1'b1;
                    state_d = S_FETCH;
                end
            end
            S_DROP: begin
                // The memory still owes us the old word; keep its address until it lands.
                inst_req  = 1'b1;
                inst_addr = drop_addr_q;
                if (inst_ack) begin
                    state_d = S_FETCH;
                end
            end
            S_ERR: begin
                if_valid = !err_acc_q;
                if_adel  = !err_acc_q;
                if (!err_acc_q && !stall) begin
                    err_acc_d = 1'b1;
                end
            end
            default: state_d = S_FETCH;
        endcase

        // A branch arriving with the PC update goes straight in; otherwise it waits
        // until the delay slot has been accepted.
        if (pc_adv) begin
            if (branch_flag) begin
                pc_d = branch_target;
            end else if (pend_valid_q) begin
                pc_d = pend_target_q;
            end else begin
                pc_d = pc_q + PC_STEP;
            end
            pend_valid_d = 1'b0;
        end else if (branch_flag && state_q != S_DROP) begin
            pend_valid_d  = 1'b1;
            pend_target_d = branch_target;
        end

        if (flush) begin
            if_valid     = 1'b0;
            if_adel      = 1'b0;
            pend_valid_d = 1'b0;
            pc_d         = new_pc;
            if (state_q == S_FETCH && !inst_ack) begin
                state_d     = S_DROP;
                drop_addr_d = pc_q;
            end else if (state_q == S_DROP && !inst_ack) begin
                state_d = S_DROP;
            end else begin
                state_d = S_FETCH;
            end
        end

        // Every path into S_FETCH funnels through here, so a misaligned PC never issues a request.
        if (state_d == S_FETCH && pc_misaligned(pc_d)) begin
            state_d   = S_ERR;
            err_acc_d = 1'b0;
        end

        if (rst) begin
            inst_req  = 1'b0;
            inst_addr = RESET_PC;
            if_pc     = RESET_PC;
            if_inst   = ZERO_WORD;
            if_valid  = 1'b0;
            if_adel   = 1'b0;
            stallreq  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_FETCH;
            pc_q          <= RESET_PC;
            pend_target_q <= ZERO_WORD;
            pend_valid_q  <= 1'b0;
            hold_inst_q   <= ZERO_WORD;
            drop_addr_q   <= ZERO_WORD;
            err_acc_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            pend_target_q <= pend_target_d;
            pend_valid_q  <= pend_valid_d;
            hold_inst_q   <= hold_inst_d;
            drop_addr_q   <= drop_addr_d;
            err_acc_q     <= err_acc_d;
        end
    end

endmodule

// File: tb/tb_if_fetch.sv
// Bench for if_fetch: directed scenarios plus a randomized run against an instruction-stream model.
// Latency: inputs driven on the falling edge, outputs sampled 2 time units later.
// Backpressure: memory acks after a random 0-2 cycle wait; stall applied at random.
module tb_if_fetch;

    localparam logic [31:0] RST_PC = 32'hBFC0_0000;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        flush;
    logic [31:0] new_pc;
    logic        branch_flag;
    logic [31:0] branch_target;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_ack;
    logic [31:0] inst_rdata;
    logic [31:0] if_pc;
    logic [31:0] if_inst;
    logic        if_valid;
    logic        if_adel;
    logic        stallreq;

    int n_checks;
    int n_pass;
    logic rst_drv;

    if_fetch #(.RESET_PC(RST_PC)) dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush), .new_pc(new_pc),
        .branch_flag(branch_flag), .branch_target(branch_target),
        .inst_req(inst_req), .inst_addr(inst_addr), .inst_ack(inst_ack), .inst_rdata(inst_rdata),
        .if_pc(if_pc), .if_inst(if_inst), .if_valid(if_valid), .if_adel(if_adel), .stallreq(stallreq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h5A3C_0F69;
    endfunction

    task automatic drive(input logic s, input logic f, input logic [31:0] np, input logic b,
                         input logic [31:0] bt, input logic a, input logic [31:0] rd);
        @(negedge clk);
        rst = rst_drv; stall = s; flush = f; new_pc = np; branch_flag = b; branch_target = bt;
        inst_ack = a; inst_rdata = rd;
        #2;
    endtask

    task automatic test_reset();
        rst_drv = 1'b1;
        for (int i = 0; i < 2; i++) begin
            drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
            n_checks++;
            if ({inst_req, if_valid, if_adel, stallreq, if_inst, if_pc, inst_addr} !== {4'b0000, 32'h0, RST_PC, RST_PC})
                $display("FAIL reset[%0d] got req=%b vld=%b adel=%b sr=%b inst=%h pc=%h addr=%h want 0,0,0,0,0,%h,%h",
                         i, inst_req, if_valid, if_adel, stallreq, if_inst, if_pc, inst_addr, RST_PC, RST_PC);
            else n_pass++;
        end
        rst_drv = 1'b0;
    endtask

    // Reset release with same-cycle ack; the branch pulse rides on the BFC00008 delay slot.
    task automatic test_seq();
        logic [31:0] a;
        for (int i = 0; i < 3; i++) begin
            a = RST_PC + 32'(4 * i);
            drive(1'b0, 1'b0, 32'h0, (i == 2), 32'h8000_0100, 1'b1, mem_word(a));
            n_checks++;
            if ({inst_req, inst_addr, if_valid, if_pc, if_inst} !== {1'b1, a, 1'b1, a, mem_word(a)})
                $display("FAIL seq[%0d] got req=%b addr=%h vld=%b pc=%h inst=%h want 1,%h,1,%h,%h",
                         i, inst_req, inst_addr, if_valid, if_pc, if_inst, a, a, mem_word(a));
            else n_pass++;
        end
    endtask

    // Ack 3 cycles late; a branch pulse during the wait must take effect after this word.
    task automatic test_late_ack();
        logic [31:0] a;
        a = 32'h8000_0100;
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b0, 32'h0, (i == 0), 32'h8000_0200, 1'b0, 32'hDEAD_BEEF);
            n_checks++;
            if ({inst_req, inst_addr, stallreq, if_valid} !== {1'b1, a, 1'b1, 1'b0})
                $display("FAIL late_wait[%0d] got req=%b addr=%h sr=%b vld=%b want 1,%h,1,0",
                         i, inst_req, inst_addr, stallreq, if_valid, a);
            else n_pass++;
        end
        drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, mem_word(a));
        n_checks++;
        if ({stallreq, if_valid, if_pc, if_inst} !== {1'b0, 1'b1, a, mem_word(a)})
            $display("FAIL late_ack got sr=%b vld=%b pc=%h inst=%h want 0,1,%h,%h",
                     stallreq, if_valid, if_pc, if_inst, a, mem_word(a));
        else n_pass++;
    endtask

    // Flush with a fetch outstanding: stale word dropped, pending branch cancelled.
    task automatic test_flush();
        drive(1'b0, 1'b0, 32'h0, 1'b1, 32'h9000_0000, 1'b0, 32'h0);
        n_checks++;
        if (inst_addr !== 32'h8000_0200)
            $display("FAIL flush_start_addr got %h want 80000200", inst_addr);
        else n_pass++;
        drive(1'b0, 1'b1, 32'h8000_0180, 1'b0, 32'h0, 1'b0, 32'h0);
        n_checks++;
        if (if_valid !== 1'b0) $display("FAIL flush_cycle_vld got %b want 0", if_valid);
        else n_pass++;
        drive(1'b0, 1'b0, 32'h0, 1'b1, 32'hA000_0000, 1'b0, 32'h0);
        n_checks++;
        if ({inst_req, inst_addr, if_valid, stallreq} !== {1'b1, 32'h8000_0200, 1'b0, 1'b0})
            $display("FAIL flush_drop got req=%b addr=%h vld=%b sr=%b want 1,80000200,0,0",
                     inst_req, inst_addr, if_valid, stallreq);
        else n_pass++;
        drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, mem_word(32'h8000_0200));
        n_checks++;
        if (if_valid !== 1'b0) $display("FAIL flush_drop_ack_vld got %b want 0", if_valid);
        else n_pass++;
        drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, mem_word(32'h8000_0180));
        n_checks++;
        if ({inst_req, inst_addr, if_valid, if_pc, if_inst} !== {1'b1, 32'h8000_0180, 1'b1, 32'h8000_0180, mem_word(32'h8000_0180)})
            $display("FAIL flush_restart got req=%b addr=%h vld=%b pc=%h inst=%h want 1,80000180,1,80000180,%h",
                     inst_req, inst_addr, if_valid, if_pc, if_inst, mem_word(32'h8000_0180));
        else n_pass++;
    endtask

    // Ack under stall: word buffered, no new request, PC advances only once stall drops.
    task automatic test_hold();
        logic [31:0] a;
        a = 32'h8000_0184;
        drive(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, mem_word(a));
        n_checks++;
        if ({inst_addr, if_valid, if_inst} !== {a, 1'b1, mem_word(a)})
            $display("FAIL hold_ack got addr=%h vld=%b inst=%h want %h,1,%h", inst_addr, if_valid, if_inst, a, mem_word(a));
        else n_pass++;
        drive(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h1234_5678);
        n_checks++;
        if ({inst_req, stallreq, if_valid, if_pc, if_inst} !== {1'b0, 1'b0, 1'b1, a, mem_word(a)})
            $display("FAIL hold_stall got req=%b sr=%b vld=%b pc=%h inst=%h want 0,0,1,%h,%h",
                     inst_req, stallreq, if_valid, if_pc, if_inst, a, mem_word(a));
        else n_pass++;
        drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        n_checks++;
        if ({inst_req, if_valid, if_inst} !== {1'b0, 1'b1, mem_word(a)})
            $display("FAIL hold_release got req=%b vld=%b inst=%h want 0,1,%h", inst_req, if_valid, if_inst, mem_word(a));
        else n_pass++;
    endtask

    // Flush to a misaligned target: address-error slot, held under stall, then parked.
    task automatic test_adel();
        drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        n_checks++;
        if ({inst_req, inst_addr} !== {1'b1, 32'h8000_0188})
            $display("FAIL adel_pre got req=%b addr=%h want 1,80000188", inst_req, inst_addr);
        else n_pass++;
        drive(1'b0, 1'b1, 32'h8000_0182, 1'b0, 32'h0, 1'b1, mem_word(32'h8000_0188));
        n_checks++;
        if (if_valid !== 1'b0) $display("FAIL adel_flush_vld got %b want 0", if_valid);
        else n_pass++;
        for (int i = 0; i < 2; i++) begin
            drive((i == 0), 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
            n_checks++;
            if ({inst_req, stallreq, if_valid, if_adel, if_pc, if_inst} !== {4'b0011, 32'h8000_0182, 32'h0})
                $display("FAIL adel_slot[%0d] got req=%b sr=%b vld=%b adel=%b pc=%h inst=%h want 0,0,1,1,80000182,0",
                         i, inst_req, stallreq, if_valid, if_adel, if_pc, if_inst);
            else n_pass++;
        end
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
            n_checks++;
            if ({inst_req, stallreq, if_valid, if_adel} !== 4'b0000)
                $display("FAIL adel_parked[%0d] got req=%b sr=%b vld=%b adel=%b want 0,0,0,0",
                         i, inst_req, stallreq, if_valid, if_adel);
            else n_pass++;
        end
        drive(1'b0, 1'b1, 32'h8000_0300, 1'b0, 32'h0, 1'b0, 32'h0);
        drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        n_checks++;
        if ({inst_req, inst_addr} !== {1'b1, 32'h8000_0300})
            $display("FAIL adel_exit got req=%b addr=%h want 1,80000300", inst_req, inst_addr);
        else n_pass++;
    endtask

    // Random stall/ack latency/branch/flush. The model tracks only the stream of accepted
    // PCs, the pending redirect and whether a flushed request is still owed by memory.
    task automatic test_random();
        logic [31:0] exp_next, redir_t, prev_addr, np, bt, rd;
        logic        redir_v, dropping, prev_wait, s, f, b, a, accepted;
        int          wait_cnt, deliveries;
        exp_next = 32'h8000_0300; redir_v = 1'b0; redir_t = 32'h0; dropping = 1'b0;
        prev_wait = 1'b0; prev_addr = 32'h0; wait_cnt = 1; deliveries = 0;
        for (int cyc = 0; cyc < 800; cyc++) begin
            @(negedge clk);
            s  = ($urandom_range(0, 9) < 3);
            f  = ($urandom_range(0, 39) == 0);
            np = 32'h8001_0000 + ($urandom_range(0, 1023) << 2);
            b  = ($urandom_range(0, 9) == 0);
            bt = 32'h8002_0000 + ($urandom_range(0, 1023) << 2);
            a  = 1'b0;
            rd = 32'hDEAD_BEEF;
            if (inst_req) begin
                if (wait_cnt == 0) begin
                    a = 1'b1;
                    rd = mem_word(inst_addr);
                    wait_cnt = $urandom_range(0, 2);
                end else begin
                    wait_cnt--;
                end
            end
            stall = s; flush = f; new_pc = np; branch_flag = b; branch_target = bt;
            inst_ack = a; inst_rdata = rd;
            #2;
            if (prev_wait) begin
                n_checks++;
                if ({inst_req, inst_addr} !== {1'b1, prev_addr})
                    $display("FAIL rnd_req_stable cyc=%0d got req=%b addr=%h want 1,%h", cyc, inst_req, inst_addr, prev_addr);
                else n_pass++;
            end
            n_checks++;
            if (stallreq !== (inst_req && !a && !dropping))
                $display("FAIL rnd_stallreq cyc=%0d got %b want %b", cyc, stallreq, inst_req && !a && !dropping);
            else n_pass++;
            if (f || dropping) begin
                n_checks++;
                if (if_valid !== 1'b0) $display("FAIL rnd_no_vld cyc=%0d got %b want 0", cyc, if_valid);
                else n_pass++;
            end
            accepted = if_valid && !s && !f;
            if (accepted) begin
                deliveries++;
                n_checks++;
                if ({if_pc, if_inst, if_adel} !== {exp_next, mem_word(exp_next), 1'b0})
                    $display("FAIL rnd_deliver cyc=%0d got pc=%h inst=%h adel=%b want %h,%h,0",
                             cyc, if_pc, if_inst, if_adel, exp_next, mem_word(exp_next));
                else n_pass++;
            end
            prev_wait = inst_req && !a;
            prev_addr = inst_addr;
            if (f) begin
                exp_next = np;
                redir_v  = 1'b0;
                dropping = inst_req && !a;
            end else begin
                if (accepted) begin
                    exp_next = b ? bt : (redir_v ? redir_t : exp_next + 32'd4);
                    redir_v  = 1'b0;
                end else if (b && !dropping) begin
                    redir_v = 1'b1;
                    redir_t = bt;
                end
                if (dropping && a) dropping = 1'b0;
            end
        end
        n_checks++;
        if (deliveries < 60) $display("FAIL rnd_progress got %0d deliveries want >= 60", deliveries);
        else n_pass++;
    endtask

    initial begin
        n_checks = 0; n_pass = 0; rst_drv = 1'b1;
        rst = 1'b1; stall = 1'b0; flush = 1'b0; new_pc = 32'h0; branch_flag = 1'b0;
        branch_target = 32'h0; inst_ack = 1'b0; inst_rdata = 32'h0;
        test_reset();
        test_seq();
        test_late_ack();
        test_flush();
        test_hold();
        test_adel();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
